// File: rtl/pc_rdata_merger.sv
// Merges per-PC HBM read beats into one wide word; 1-cycle skew FIFOs + output register, 2 edges push-to-valid.
// Each PC is back-pressured only by its own registered FIFO count; downstream stalls hold the output stable.

module pc_rdata_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module pc_rdata_merger #(
  parameter int PC_NB      = 4,
  parameter int PC_DATA_W  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic [PC_NB*PC_DATA_W-1:0] in_pc_data,
  input  logic [PC_NB-1:0]           in_pc_last,
  input  logic [PC_NB-1:0]           in_pc_vld,
  output logic [PC_NB-1:0]           in_pc_rdy,
  output logic [PC_NB*PC_DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [CNT_W-1:0]           out_cnt,
  input  logic                       err_clr,
  output logic                       err_last_mismatch
);
  typedef struct packed {
    logic                 last;
    logic [PC_DATA_W-1:0] dat;
  } beat_t;

  beat_t                      push_beat [PC_NB];
  beat_t                      pop_beat  [PC_NB];
  logic [PC_NB-1:0]           fifo_full;
  logic [PC_NB-1:0]           fifo_empty;
  logic [PC_NB-1:0]           head_last;
  logic [PC_NB*PC_DATA_W-1:0] merged_dat;
  logic                       pop_all;
  logic                       last_mismatch;

  generate
    for (genvar g = 0; g < PC_NB; g++) begin : g_pc
      assign push_beat[g] = '{last: in_pc_last[g], dat: in_pc_data[g*PC_DATA_W +: PC_DATA_W]};
      // Ready comes from the registered count only, never from out_rdy.
      assign in_pc_rdy[g] = ~a_rst & ~fifo_full[g];
      assign head_last[g] = pop_beat[g].last;
      assign merged_dat[g*PC_DATA_W +: PC_DATA_W] = pop_beat[g].dat;

      pc_rdata_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk      (clk),
        .a_rst    (a_rst),
        .push     (in_pc_vld[g] & in_pc_rdy[g]),
        .push_dat (push_beat[g]),
        .pop      (pop_all),
        .pop_dat  (pop_beat[g]),
        .full     (fifo_full[g]),
        .empty    (fifo_empty[g])
      );
    end
  endgenerate

  assign pop_all       = ~|fifo_empty & (~out_vld | out_rdy);
  assign last_mismatch = |(head_last ^ {PC_NB{head_last[0]}});

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (pop_all) begin
      out_vld  <= 1'b1;
      out_data <= merged_dat;
      out_last <= head_last[0];
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      out_cnt <= '0;
    end else if (out_vld & out_rdy) begin
      out_cnt <= out_cnt + 1'b1;
    end
  end

  // A new mismatch takes priority over a coincident clear.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      err_last_mismatch <= 1'b0;
    end else if (pop_all & last_mismatch) begin
      err_last_mismatch <= 1'b1;
    end else if (err_clr) begin
      err_last_mismatch <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_rdata_merger.sv
// Directed bench: 4-PC merger with 16-bit slices {tag,pc,beat}, plus a 1-PC instance with a 4-bit counter.
module tb_pc_rdata_merger;
  localparam int NB = 4;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             a_rst;
  logic [NB*DW-1:0] in_pc_data;
  logic [NB-1:0]    in_pc_last, in_pc_vld, in_pc_rdy;
  logic [NB*DW-1:0] out_data;
  logic             out_last, out_vld, out_rdy;
  logic [31:0]      out_cnt;
  logic             err_clr, err_last_mismatch;

  logic [7:0] w_in_data, w_out_data;
  logic       w_in_last, w_in_vld, w_in_rdy, w_out_last, w_out_vld, w_out_rdy;
  logic [3:0] w_out_cnt;
  logic       w_err_clr, w_err;

  pc_rdata_merger #(.PC_NB(NB), .PC_DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .a_rst(a_rst), .in_pc_data(in_pc_data), .in_pc_last(in_pc_last),
    .in_pc_vld(in_pc_vld), .in_pc_rdy(in_pc_rdy), .out_data(out_data), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_cnt(out_cnt), .err_clr(err_clr),
    .err_last_mismatch(err_last_mismatch));

  pc_rdata_merger #(.PC_NB(1), .PC_DATA_W(8), .FIFO_DEPTH(2), .CNT_W(4)) dut_w (
    .clk(clk), .a_rst(a_rst), .in_pc_data(w_in_data), .in_pc_last(w_in_last),
    .in_pc_vld(w_in_vld), .in_pc_rdy(w_in_rdy), .out_data(w_out_data), .out_last(w_out_last),
    .out_vld(w_out_vld), .out_rdy(w_out_rdy), .out_cnt(w_out_cnt), .err_clr(w_err_clr),
    .err_last_mismatch(w_err));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int idx[NB], nbeats[NB], delay[NB], last_at[NB];
  int src_tag, cyc, stall_start, stall_len;
  bit src_en;
  logic [NB*DW-1:0] got_dat[$];
  logic             got_last[$];

  function automatic logic [NB*DW-1:0] exp_word(int tag, int k);
    logic [NB*DW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*DW +: DW] = {4'(tag), 4'(i), 8'(k)};
    return w;
  endfunction

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      in_pc_vld[i] = (cyc >= delay[i]) && (idx[i] < nbeats[i]);
      in_pc_data[i*DW +: DW] = {4'(src_tag), 4'(i), 8'(idx[i])};
      in_pc_last[i] = (idx[i] == last_at[i]);
    end
    out_rdy = !(cyc >= stall_start && cyc < stall_start + stall_len);
  endtask

  task automatic start_src(int tag, int n, int d3, int l_all, int l2, int s_start, int s_len);
    for (int i = 0; i < NB; i++) begin
      idx[i] = 0;
      nbeats[i] = n;
      delay[i] = (i == 3) ? d3 : 0;
      last_at[i] = (i == 2) ? l2 : l_all;
    end
    src_tag = tag;
    cyc = 0;
    stall_start = s_start;
    stall_len = s_len;
    got_dat.delete();
    got_last.delete();
    src_en = 1'b1;
    drive();
  endtask

  // Samples handshakes just before the edge, then advances the sources.
  task automatic step();
    logic [NB-1:0] fire;
    #1;
    fire = in_pc_vld & in_pc_rdy;
    if (out_vld && out_rdy) begin
      got_dat.push_back(out_data);
      got_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) if (fire[i]) idx[i]++;
    cyc++;
    if (src_en) drive();
  endtask

  task automatic test_reset();
    a_rst = 1'b0; in_pc_vld = '0; in_pc_data = '0; in_pc_last = '0; out_rdy = 1'b0; err_clr = 1'b0;
    w_in_vld = 1'b0; w_in_data = '0; w_in_last = 1'b0; w_out_rdy = 1'b0; w_err_clr = 1'b0;
    src_en = 1'b0;
    #1 a_rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    vectors++; if (out_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_out_cnt got %0d exp 0", out_cnt); end
    vectors++; if (err_last_mismatch !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_last_mismatch); end
    vectors++; if (in_pc_rdy !== 4'h0) begin miscompares++; $display("FAIL reset_rdy_in_reset got %b exp 0000", in_pc_rdy); end
    @(posedge clk);
    #1 a_rst = 1'b0;
    #1;
    vectors++; if (in_pc_rdy !== 4'hF) begin miscompares++; $display("FAIL reset_rdy_release got %b exp 1111", in_pc_rdy); end
    vectors++; if (w_in_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_w_rdy_release got %b exp 1", w_in_rdy); end
  endtask

  task automatic test_aligned();
    int first_push = -1, first_vld = -1;
    bit bubble = 1'b0;
    start_src(1, 16, 0, 15, 15, 0, 0);
    for (int c = 0; c < 100 && got_dat.size() < 16; c++) begin
      step();
      if (first_push < 0 && idx[0] > 0) first_push = cyc;
      if (first_vld < 0 && out_vld) first_vld = cyc;
      if (first_vld >= 0 && !out_vld && got_dat.size() < 16) bubble = 1'b1;
    end
    vectors++; if (got_dat.size() != 16) begin miscompares++; $display("FAIL aligned_count got %0d exp 16", got_dat.size()); end
    vectors++; if (first_vld != first_push + 1) begin miscompares++; $display("FAIL aligned_latency vld_edge %0d exp %0d", first_vld, first_push + 1); end
    vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL aligned_bubble got %b exp 0", bubble); end
    for (int k = 0; k < got_dat.size(); k++) begin
      vectors++;
      if ({got_last[k], got_dat[k]} !== {(k == 15), exp_word(1, k)}) begin
        miscompares++; $display("FAIL aligned_word%0d got %b/%h exp %b/%h", k, got_last[k], got_dat[k], (k == 15), exp_word(1, k));
      end
    end
    vectors++; if (out_cnt !== 32'd16) begin miscompares++; $display("FAIL aligned_out_cnt got %0d exp 16", out_cnt); end
  endtask

  task automatic test_skew();
    bit dropped = 1'b0, early = 1'b0;
    start_src(2, 12, 10, 11, 11, 0, 0);
    for (int c = 0; c < 200 && got_dat.size() < 12; c++) begin
      step();
      if (!dropped && in_pc_rdy[0] == 1'b0) begin
        dropped = 1'b1;
        vectors++; if (idx[0] != 8) begin miscompares++; $display("FAIL skew_beats_at_drop got %0d exp 8", idx[0]); end
        vectors++; if (in_pc_rdy !== 4'b1000) begin miscompares++; $display("FAIL skew_rdy_at_drop got %b exp 1000", in_pc_rdy); end
      end
      if (out_vld && idx[3] == 0) early = 1'b1;
    end
    vectors++; if (dropped !== 1'b1) begin miscompares++; $display("FAIL skew_rdy_dropped got %b exp 1", dropped); end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL skew_early_word got %b exp 0", early); end
    vectors++; if (got_dat.size() != 12) begin miscompares++; $display("FAIL skew_count got %0d exp 12", got_dat.size()); end
    for (int k = 0; k < got_dat.size(); k++) begin
      vectors++;
      if ({got_last[k], got_dat[k]} !== {(k == 11), exp_word(2, k)}) begin
        miscompares++; $display("FAIL skew_word%0d got %h exp %h", k, got_dat[k], exp_word(2, k));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [NB*DW-1:0] held = '0;
    bit held_ok = 1'b0, unstable = 1'b0;
    start_src(3, 20, 0, 19, 19, 4, 10);
    for (int c = 0; c < 200 && got_dat.size() < 20; c++) begin
      step();
      if (!out_rdy) begin
        if (!out_vld) unstable = 1'b1;
        else if (!held_ok) begin held = out_data; held_ok = 1'b1; end
        else if (out_data !== held) unstable = 1'b1;
      end
      if (cyc == 13) begin
        vectors++; if (in_pc_rdy !== 4'h0) begin miscompares++; $display("FAIL bp_rdy_full got %b exp 0000", in_pc_rdy); end
      end
    end
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL bp_stable got %b exp 0", unstable); end
    vectors++; if (held !== exp_word(3, 2)) begin miscompares++; $display("FAIL bp_held_word got %h exp %h", held, exp_word(3, 2)); end
    vectors++; if (got_dat.size() != 20) begin miscompares++; $display("FAIL bp_count got %0d exp 20", got_dat.size()); end
    for (int k = 0; k < got_dat.size(); k++) begin
      vectors++;
      if (got_dat[k] !== exp_word(3, k)) begin
        miscompares++; $display("FAIL bp_word%0d got %h exp %h", k, got_dat[k], exp_word(3, k));
      end
    end
  endtask

  task automatic test_last_mismatch();
    bit seen2 = 1'b0, seen3 = 1'b0;
    start_src(4, 8, 0, 4, 3, 0, 0);
    for (int c = 0; c < 100 && got_dat.size() < 8; c++) begin
      step();
      if (!seen2 && out_vld && out_data === exp_word(4, 2)) begin
        seen2 = 1'b1;
        vectors++; if (err_last_mismatch !== 1'b0) begin miscompares++; $display("FAIL lm_err_word2 got %b exp 0", err_last_mismatch); end
      end
      if (!seen3 && out_vld && out_data === exp_word(4, 3)) begin
        seen3 = 1'b1;
        vectors++; if (err_last_mismatch !== 1'b1) begin miscompares++; $display("FAIL lm_err_word3 got %b exp 1", err_last_mismatch); end
      end
    end
    vectors++; if (got_dat.size() != 8) begin miscompares++; $display("FAIL lm_count got %0d exp 8", got_dat.size()); end
    for (int k = 0; k < got_dat.size(); k++) begin
      vectors++;
      if ({got_last[k], got_dat[k]} !== {(k == 4), exp_word(4, k)}) begin
        miscompares++; $display("FAIL lm_word%0d got %b/%h exp %b/%h", k, got_last[k], got_dat[k], (k == 4), exp_word(4, k));
      end
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vectors++; if (err_last_mismatch !== 1'b0) begin miscompares++; $display("FAIL lm_clear got %b exp 0", err_last_mismatch); end
    src_en = 1'b0;
    in_pc_data = exp_word(5, 0);
    in_pc_last = 4'b0010;
    in_pc_vld = 4'hF;
    out_rdy = 1'b1;
    step();
    in_pc_vld = 4'h0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vectors++; if (err_last_mismatch !== 1'b1) begin miscompares++; $display("FAIL lm_set_wins got %b exp 1", err_last_mismatch); end
    vectors++;
    if ({out_vld, out_last, out_data} !== {1'b1, 1'b0, exp_word(5, 0)}) begin
      miscompares++; $display("FAIL lm_coincident_word got %b/%b/%h exp 1/0/%h", out_vld, out_last, out_data, exp_word(5, 0));
    end
    step();
  endtask

  task automatic test_async_reset();
    start_src(6, 4, 0, 3, 3, 0, 1000);
    repeat (8) step();
    vectors++; if ({out_vld, in_pc_rdy} !== 5'b1_1111) begin miscompares++; $display("FAIL ar_prefill got %b/%b exp 1/1111", out_vld, in_pc_rdy); end
    src_en = 1'b0;
    #3 a_rst = 1'b1;
    in_pc_vld = '0;
    #1;
    vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL ar_out_vld got %b exp 0", out_vld); end
    vectors++; if (out_cnt !== 32'd0) begin miscompares++; $display("FAIL ar_out_cnt got %0d exp 0", out_cnt); end
    vectors++; if (in_pc_rdy !== 4'h0) begin miscompares++; $display("FAIL ar_rdy got %b exp 0000", in_pc_rdy); end
    @(posedge clk);
    #1 a_rst = 1'b0;
    start_src(7, 2, 0, 1, 1, 0, 0);
    repeat (12) step();
    vectors++; if (got_dat.size() != 2) begin miscompares++; $display("FAIL ar_count got %0d exp 2", got_dat.size()); end
    for (int k = 0; k < got_dat.size(); k++) begin
      vectors++;
      if (got_dat[k] !== exp_word(7, k)) begin
        miscompares++; $display("FAIL ar_word%0d got %h exp %h", k, got_dat[k], exp_word(7, k));
      end
    end
    vectors++; if (out_cnt !== 32'd2) begin miscompares++; $display("FAIL ar_post_cnt got %0d exp 2", out_cnt); end
  endtask

  task automatic test_cnt_wrap();
    int pushed = 0, popped = 0;
    logic pf, of;
    for (int c = 0; c < 100 && popped < 17; c++) begin
      w_in_vld = (pushed < 17);
      w_in_data = 8'(pushed);
      w_in_last = pushed[0];
      w_out_rdy = 1'b1;
      #1;
      pf = w_in_vld & w_in_rdy;
      of = w_out_vld & w_out_rdy;
      if (of) begin
        vectors++; if (w_out_data !== 8'(popped)) begin miscompares++; $display("FAIL wrap_word%0d got %0d exp %0d", popped, w_out_data, popped); end
      end
      @(posedge clk);
      #1;
      if (pf) pushed++;
      if (of) begin
        popped++;
        if (popped == 16) begin
          vectors++; if (w_out_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_at16 got %0d exp 0", w_out_cnt); end
        end
      end
    end
    w_in_vld = 1'b0;
    vectors++; if (popped != 17) begin miscompares++; $display("FAIL wrap_handshakes got %0d exp 17", popped); end
    vectors++; if (w_out_cnt !== 4'd1) begin miscompares++; $display("FAIL wrap_cnt got %0d exp 1", w_out_cnt); end
    vectors++; if (w_err !== 1'b0) begin miscompares++; $display("FAIL wrap_single_pc_err got %b exp 0", w_err); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_back_pressure();
    test_last_mismatch();
    test_async_reset();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "timeout");
  end
endmodule
